fib_seq_engine: RTL
===================

# fib_seq_engine

Parametrised successor to the fixed-width Fibonacci unit. It computes the n-th term of a selectable linear recurrence: Fibonacci, Lucas, user-seeded two-term, or Tribonacci. Computation is iterative, one addition step per clock, with a start/busy/done handshake, an abort input and an exact overflow flag. It sits behind the same start/done control style as the existing sequence units.

## Interface
- N_WIDTH, 7: width of the term index n.
- ANS_WIDTH, 121: width of the result and of the internal term registers.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- mode  in  2  0 Fibonacci (seeds 0,1); 1 Lucas (2,1); 2 custom (seed0, seed1); 3 Tribonacci (0,0,1).
- n  in  N_WIDTH  index of the requested term; term 0 is the first seed.
- seed0  in  ANS_WIDTH  custom term 0 (mode 2 only).
- seed1  in  ANS_WIDTH  custom term 1 (mode 2 only).
- busy  out  1  high in CALC.
- done  out  1  high in DONE; held until the next accepted start or abort.
- ans  out  ANS_WIDTH  term n modulo 2^ANS_WIDTH; held in DONE.
- overflow  out  1  term n exceeded ANS_WIDTH bits; valid while done.

## Operation
- States: IDLE, CALC, DONE.
- Reset (reset=0): state IDLE, busy=0, done=0, ans=0, overflow=0, and all term registers and the counter cleared.
- Start acceptance: in IDLE or DONE with start=1 and abort=0, the following happen at that edge:
  - mode is captured.
  - Counter cnt is loaded with n.
  - Term registers r0, r1, r2 are loaded with terms 0, 1, 2 of the selected sequence. For two-term modes, r2 = r0 + r1.
  - Per-register overflow bits ov0..ov2 are cleared; for mode 2, ov2 takes the carry of seed0 + seed1.
  - done is cleared; next state is CALC.
- CALC, cnt ≠ 0:
  - r0 ← r1, r1 ← r2.
  - r2 ← r1 + r2 (two-term modes) or r0 + r1 + r2 (Tribonacci), truncated to ANS_WIDTH.
  - Overflow bits shift alongside the terms. The new ov2 = carry-out(s) of the sum OR any ov of its operands.
  - cnt decrements.
- CALC, cnt = 0: ans ← r0, overflow ← ov0, done ← 1, next state DONE.
- Overflow reflects term n only. Carries produced by look-ahead terms r1/r2 must never reach the overflow output.
- Tribonacci sum uses ANS_WIDTH+2-bit intermediate; any nonzero bit above ANS_WIDTH sets the overflow bit.
- start while busy is ignored. n, mode and seeds may change freely during CALC without effect.
- abort (any state): next state IDLE, busy=0, done=0; ans and overflow keep their previous values. abort wins over a simultaneous start.
- Reset mid-CALC: immediate return to reset values, with no partial result exposed.

## Timing
- Start accepted at edge E0.
- Edges E1..En perform the n shift steps.
- Edge E(n+1) writes ans and raises done, so latency is n+1 cycles from acceptance to done.
- n=0: done after 1 cycle with ans = term 0.
- busy is high from the cycle after E0 through E(n+1), where it falls with done rising.
- Back-to-back: a start in the first DONE cycle is accepted. done drops at that edge and the new result appears n+1 edges later.
- Maximum latency is 2^N_WIDTH cycles.

## Structure
- Package fib_seq_pkg holds:
  - the mode enum (FIB, LUCAS, CUSTOM, TRIB);
  - the state enum (IDLE, CALC, DONE);
  - localparams for the fixed seed triples.
- One sub-module, fib_seq_step: a combinational next-term adder (two- or three-operand, mode-selected) that returns the truncated sum and an overflow bit. The FSM, counter and registers stay in fib_seq_engine.

## Test plan
- Fibonacci, defaults, n = 6, 3, 8, 15, 25 with reset between runs -> ans = 8, 2, 21, 610, 75025; overflow=0; done exactly n+1 cycles after start.
- Lucas n=5 -> 11; Tribonacci n=10 -> 81; custom seed0=3, seed1=4, n=4 -> 18; n=0 in each mode -> term 0 after 1 cycle.
- ANS_WIDTH=8, Fibonacci: n=13 -> ans=233, overflow=0 (look-ahead terms overflow but are masked); n=14 -> ans=121, overflow=1.
- start pulsed mid-CALC and n changed mid-CALC -> ignored, original result unchanged; back-to-back start in first DONE cycle -> new result correct.
- abort at step 3 of n=20 -> IDLE next cycle, busy=0, done=0, prior ans retained; abort+start same edge -> IDLE.
- reset asserted asynchronously mid-CALC (between edges) -> all outputs 0 immediately; after release, fresh n=7 run -> 13.

Source files
------------

// File: rtl/fib_seq_pkg.sv
// fib_seq_pkg: shared mode/state enums and fixed seed triples for the sequence engine
package fib_seq_pkg;
  typedef enum logic [1:0] {FIB, LUCAS, CUSTOM, TRIB} mode_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  localparam logic [2:0][1:0] FIB_SEEDS   = {2'd1, 2'd1, 2'd0};
  localparam logic [2:0][1:0] LUCAS_SEEDS = {2'd3, 2'd1, 2'd2};
  localparam logic [2:0][1:0] TRIB_SEEDS  = {2'd1, 2'd0, 2'd0};
endpackage

// File: rtl/fib_seq_if.sv
// fib_seq_if: start/done control and data bundle between a requester and the sequence engine
interface fib_seq_if #(parameter int N_WIDTH = 7, parameter int ANS_WIDTH = 121);
  logic                 start;
  logic                 abort;
  logic [1:0]           mode;
  logic [N_WIDTH-1:0]   n;
  logic [ANS_WIDTH-1:0] seed0;
  logic [ANS_WIDTH-1:0] seed1;
  logic                 busy;
  logic                 done;
  logic [ANS_WIDTH-1:0] ans;
  logic                 overflow;
  modport master(output start, abort, mode, n, seed0, seed1, input busy, done, ans, overflow);
  modport slave(input start, abort, mode, n, seed0, seed1, output busy, done, ans, overflow);
endinterface

// File: rtl/fib_seq_step.sv
// fib_seq_step: next-term adder, two operands or three for Tribonacci, with sticky overflow
module fib_seq_step #(parameter int W = 121) (
  input  logic         trib,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic         ova,
  input  logic         ovb,
  input  logic         ovc,
  output logic [W-1:0] sum,
  output logic         ov
);
  localparam int XW = W + 2;
  logic [XW-1:0] wide;
  always_comb begin
    wide = XW'(b) + XW'(c) + (trib ? XW'(a) : '0);
    sum  = wide[W-1:0];
    ov   = (|wide[XW-1:W]) | ovb | ovc | (trib & ova);
  end
endmodule

// File: rtl/fib_seq_engine.sv
// fib_seq_engine: iterative n-th term of Fibonacci/Lucas/custom/Tribonacci recurrences
module fib_seq_engine import fib_seq_pkg::*; #(
  parameter int N_WIDTH   = 7,
  parameter int ANS_WIDTH = 121
) (
  input logic      clk,
  input logic      reset,
  fib_seq_if.slave bus
);
  state_e               state, state_n;
  mode_e                md, mi;
  logic [N_WIDTH-1:0]   cnt;
  logic [ANS_WIDTH-1:0] r0, r1, r2, sum, ans_q, s0, s1, s2;
  logic                 ov0, ov1, ov2, ov_sum, ovf_q, accept;
  logic [ANS_WIDTH:0]   csum;
  logic [2:0][1:0]      fixed;
  assign mi           = mode_e'(bus.mode);
  assign bus.busy     = state == CALC;
  assign bus.done     = state == DONE;
  assign bus.ans      = ans_q;
  assign bus.overflow = ovf_q;
  fib_seq_step #(.W(ANS_WIDTH)) u_step (
    .trib(md == TRIB), .a(r0), .b(r1), .c(r2),
    .ova(ov0), .ovb(ov1), .ovc(ov2), .sum(sum), .ov(ov_sum)
  );
  always_comb begin
    fixed = mi == FIB ? FIB_SEEDS : mi == LUCAS ? LUCAS_SEEDS : TRIB_SEEDS;
    csum  = {1'b0, bus.seed0} + {1'b0, bus.seed1};
    s0    = mi == CUSTOM ? bus.seed0 : ANS_WIDTH'(fixed[0]);
    s1    = mi == CUSTOM ? bus.seed1 : ANS_WIDTH'(fixed[1]);
    s2    = mi == CUSTOM ? csum[ANS_WIDTH-1:0] : ANS_WIDTH'(fixed[2]);
  end
  always_comb begin
    accept  = state != CALC && bus.start && !bus.abort;
    state_n = bus.abort ? IDLE : accept ? CALC : (state == CALC && cnt == '0) ? DONE : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  // abort freezes everything, so ans/overflow keep the last delivered result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md    <= FIB;
      cnt   <= '0;
      {r0, r1, r2}    <= '0;
      {ov0, ov1, ov2} <= '0;
      ans_q <= '0;
      ovf_q <= 1'b0;
    end else if (!bus.abort) begin
      if (accept) begin
        md  <= mi;
        cnt <= bus.n;
        r0  <= s0;
        r1  <= s1;
        r2  <= s2;
        {ov0, ov1} <= 2'b00;
        ov2 <= mi == CUSTOM && csum[ANS_WIDTH];
      end else if (state == CALC) begin
        if (cnt != '0) begin
          {r0, r1, r2}    <= {r1, r2, sum};
          {ov0, ov1, ov2} <= {ov1, ov2, ov_sum};
          cnt <= cnt - 1'b1;
        end else begin
          ans_q <= r0;
          ovf_q <= ov0;
        end
      end
    end
  end
endmodule
